rc4_key_search_ctrl: RTL and testbench

Master controller for the RC4 cracking datapath. For each candidate secret key it sequences three sub-FSMs in order, each through a start/done handshake: S-memory init, key schedule (swap), and decryptor. It then scans the decrypted message for valid plaintext and either reports the key or advances to the next one. It sits above the three sub-FSMs and owns their start and reset lines.

---
 rtl/rc4_key_search_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key search master controller.
// Sequences init, key-schedule and decrypt sub-FSMs per candidate key.
module rc4_key_search_ctrl #(
    parameter int                   MSG_DEP        = 32,
    parameter int                   MSG_WIDTH      = 8,
    parameter int                   KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_FIRST      = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST       = 24'h3FFFFF,
    parameter int                   TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              go,
    input  logic                              abort,
    input  logic                              init_done,
    input  logic                              ksa_done,
    input  logic                              dec_done,
    input  logic [MSG_DEP-1:0][MSG_WIDTH-1:0] decrypted_data,
    output logic                              sub_reset,
    output logic                              init_start,
    output logic                              ksa_start,
    output logic                              dec_start,
    output logic [KEY_WIDTH-1:0]              secret_key,
    output logic                              busy,
    output logic                              key_found,
    output logic                              search_failed,
    output logic                              timeout_err
);

    localparam int IW = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RESET_SUBS,
        S_WAIT_INIT,
        S_WAIT_KSA,
        S_WAIT_DEC,
        S_CHECK,
        S_NEXT_KEY,
        S_FOUND,
        S_FAILED
    } state_t;

    state_t               state;
    logic [IW-1:0]        chk_idx;
    logic [TW-1:0]        tcnt;
    logic                 phase_done;
    logic                 tmo_hit;
    logic                 byte_ok;
    logic [MSG_WIDTH-1:0] cur_byte;

    // Done of the sub-FSM owning the current WAIT state; others ignored.
    always_comb begin
        phase_done = 1'b0;
        unique case (1'b1)
            state == S_WAIT_INIT: phase_done = init_done;
            state == S_WAIT_KSA:  phase_done = ksa_done;
            state == S_WAIT_DEC:  phase_done = dec_done;
            default:              phase_done = 1'b0;
        endcase
    end

    // Plaintext byte classifier: lowercase letters or space.
    always_comb begin
        cur_byte = decrypted_data[chk_idx];
        byte_ok  = ((cur_byte >= MSG_WIDTH'(97)) &&
                    (cur_byte <= MSG_WIDTH'(122))) ||
                   (cur_byte == MSG_WIDTH'(32));
        tmo_hit  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            secret_key    <= KEY_FIRST;
            sub_reset     <= 1'b1;
            init_start    <= 1'b0;
            ksa_start     <= 1'b0;
            dec_start     <= 1'b0;
            busy          <= 1'b0;
            key_found     <= 1'b0;
            search_failed <= 1'b0;
            timeout_err   <= 1'b0;
            chk_idx       <= '0;
            tcnt          <= '0;
        end else if (abort && busy) begin
            state      <= S_IDLE;
            sub_reset  <= 1'b1;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            busy       <= 1'b0;
            tcnt       <= '0;
            chk_idx    <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_FOUND, S_FAILED: begin
                    if (go) begin
                        secret_key    <= KEY_FIRST;
                        key_found     <= 1'b0;
                        search_failed <= 1'b0;
                        timeout_err   <= 1'b0;
                        sub_reset     <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_RESET_SUBS;
                    end
                end
                S_RESET_SUBS: begin
                    sub_reset  <= 1'b0;
                    init_start <= 1'b1;
                    tcnt       <= '0;
                    state      <= S_WAIT_INIT;
                end
                S_WAIT_INIT, S_WAIT_KSA, S_WAIT_DEC: begin
                    if (phase_done) begin
                        tcnt <= '0;
                        if (state == S_WAIT_INIT) begin
                            init_start <= 1'b0;
                            ksa_start  <= 1'b1;
                            state      <= S_WAIT_KSA;
                        end else if (state == S_WAIT_KSA) begin
                            ksa_start <= 1'b0;
                            dec_start <= 1'b1;
                            state     <= S_WAIT_DEC;
                        end else begin
                            dec_start <= 1'b0;
                            chk_idx   <= '0;
                            state     <= S_CHECK;
                        end
                    end else if (tmo_hit) begin
                        init_start  <= 1'b0;
                        ksa_start   <= 1'b0;
                        dec_start   <= 1'b0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        tcnt        <= '0;
                        state       <= S_FAILED;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!byte_ok) begin
                        state <= S_NEXT_KEY;
                    end else if (chk_idx == IW'(MSG_DEP - 1)) begin
                        key_found <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FOUND;
                    end else begin
                        chk_idx <= chk_idx + 1'b1;
                    end
                end
                S_NEXT_KEY: begin
                    if (secret_key == KEY_LAST) begin
                        search_failed <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_FAILED;
                    end else begin
                        secret_key <= secret_key + 1'b1;
                        sub_reset  <= 1'b1;
                        state      <= S_RESET_SUBS;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with stub sub-FSMs.
// Two instances: default key range, and a 10..12 key range.
module tb_rc4_key_search_ctrl;

    localparam int S_FOUND = 0;
    localparam int S_SFAIL = 1;
    localparam int S_TMO   = 2;
    localparam int S_INIT  = 3;
    localparam int S_KSA   = 4;
    localparam int S_DEC   = 5;
    localparam int S_SRST  = 6;
    localparam int S_NDEC  = 7;

    logic clk = 1'b0;
    logic reset_n;
    logic go [2];
    logic abort [2];
    logic init_done [2];
    logic ksa_done [2];
    logic dec_done [2];
    logic [31:0][7:0] data0;
    logic [31:0][7:0] data1;
    logic sub_reset [2];
    logic init_start [2];
    logic ksa_start [2];
    logic dec_start [2];
    logic [23:0] secret_key [2];
    logic busy [2];
    logic key_found [2];
    logic search_failed [2];
    logic timeout_err [2];

    logic [2:0] sdone [2];
    logic [2:0] st [2];
    int scnt [2][3];
    logic ksa_hang;
    logic spur;
    int mode;
    int rs_count1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(
        .TIMEOUT_CYCLES(16)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .go(go[0]), .abort(abort[0]),
        .init_done(init_done[0]), .ksa_done(ksa_done[0]),
        .dec_done(dec_done[0]), .decrypted_data(data0),
        .sub_reset(sub_reset[0]), .init_start(init_start[0]),
        .ksa_start(ksa_start[0]), .dec_start(dec_start[0]),
        .secret_key(secret_key[0]), .busy(busy[0]),
        .key_found(key_found[0]), .search_failed(search_failed[0]),
        .timeout_err(timeout_err[0])
    );

    rc4_key_search_ctrl #(
        .KEY_FIRST(24'd10),
        .KEY_LAST(24'd12),
        .TIMEOUT_CYCLES(16)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .go(go[1]), .abort(abort[1]),
        .init_done(init_done[1]), .ksa_done(ksa_done[1]),
        .dec_done(dec_done[1]), .decrypted_data(data1),
        .sub_reset(sub_reset[1]), .init_start(init_start[1]),
        .ksa_start(ksa_start[1]), .dec_start(dec_start[1]),
        .secret_key(secret_key[1]), .busy(busy[1]),
        .key_found(key_found[1]), .search_failed(search_failed[1]),
        .timeout_err(timeout_err[1])
    );

    assign st[0] = {dec_start[0], ksa_start[0], init_start[0]};
    assign st[1] = {dec_start[1], ksa_start[1], init_start[1]};
    assign init_done[0] = sdone[0][0] | spur;
    assign ksa_done[0]  = sdone[0][1];
    assign dec_done[0]  = sdone[0][2];
    assign init_done[1] = sdone[1][0];
    assign ksa_done[1]  = sdone[1][1];
    assign dec_done[1]  = sdone[1][2];

    // Stub sub-FSMs: sticky done 5 cycles into start, cleared by sub_reset.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (sub_reset[i]) begin
                    sdone[i][j] <= 1'b0;
                    scnt[i][j]  <= 0;
                end else if (st[i][j] && !sdone[i][j] &&
                             !(i == 0 && j == 1 && ksa_hang)) begin
                    if (scnt[i][j] == 4) sdone[i][j] <= 1'b1;
                    else scnt[i][j] <= scnt[i][j] + 1;
                end
            end
        end
    end

    // Count cycles instance 1 spends in RESET_SUBS (one per key tried).
    always @(posedge clk) begin
        if (!reset_n) rs_count1 <= 0;
        else if (sub_reset[1] && busy[1]) rs_count1 <= rs_count1 + 1;
    end

    // Decryptor output models keyed on the candidate key.
    always_comb begin
        data0 = {32{8'h61}};
        if (mode == 1) begin
            if (secret_key[0] == 24'd0) data0[3] = 8'h41;
            else if (secret_key[0] == 24'd1) data0[3] = 8'h60;
            else if (secret_key[0] == 24'd2) data0[3] = 8'h7B;
            else begin
                for (int i = 0; i < 32; i++) begin
                    if (i % 3 == 0) data0[i] = 8'h61;
                    else if (i % 3 == 1) data0[i] = 8'h7A;
                    else data0[i] = 8'h20;
                end
            end
        end else if (mode == 2) begin
            if (secret_key[0] < 24'd7) data0[0] = 8'h1F;
        end
        data1 = {32{8'h61}};
        data1[0] = 8'h7B;
    end

    function automatic logic sig(input int i, input int s);
        case (s)
            S_FOUND: return key_found[i];
            S_SFAIL: return search_failed[i];
            S_TMO:   return timeout_err[i];
            S_INIT:  return init_start[i];
            S_KSA:   return ksa_start[i];
            S_DEC:   return dec_start[i];
            S_SRST:  return sub_reset[i];
            S_NDEC:  return !dec_start[i];
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int i, input int s, input int lim,
                              input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sig(i, s) && cyc < lim);
        chk({tag, "_wait"}, 64'(sig(i, s)), 64'd1);
    endtask

    task automatic chk_reset(input int i, input logic [23:0] k,
                             input string tag);
        chk({tag, "_srst"}, 64'(sub_reset[i]), 64'd1);
        chk({tag, "_istart"}, 64'(init_start[i]), 64'd0);
        chk({tag, "_kstart"}, 64'(ksa_start[i]), 64'd0);
        chk({tag, "_dstart"}, 64'(dec_start[i]), 64'd0);
        chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
        chk({tag, "_found"}, 64'(key_found[i]), 64'd0);
        chk({tag, "_sfail"}, 64'(search_failed[i]), 64'd0);
        chk({tag, "_tmo"}, 64'(timeout_err[i]), 64'd0);
        chk({tag, "_key"}, 64'(secret_key[i]), 64'(k));
    endtask

    task automatic pulse_go(input int i);
        go[i] = 1'b1;
        @(negedge clk);
        go[i] = 1'b0;
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        go[0] = 1'b0; go[1] = 1'b0;
        abort[0] = 1'b0; abort[1] = 1'b0;
        ksa_hang = 1'b0; spur = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        chk_reset(0, 24'd0, "rst0");
        chk_reset(1, 24'd10, "rst1");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_srst", 64'(sub_reset[0]), 64'd1);

        // Single key, all-valid message.
        pulse_go(0);
        chk("t1_rs_srst", 64'(sub_reset[0]), 64'd1);
        chk("t1_rs_busy", 64'(busy[0]), 64'd1);
        chk("t1_rs_istart", 64'(init_start[0]), 64'd0);
        @(negedge clk);
        chk("t1_wi_istart", 64'(init_start[0]), 64'd1);
        chk("t1_wi_srst", 64'(sub_reset[0]), 64'd0);
        wait_until(0, S_KSA, 50, "t1_ksa", cyc);
        chk("t1_ksa_istart", 64'(init_start[0]), 64'd0);
        wait_until(0, S_DEC, 50, "t1_dec", cyc);
        chk("t1_dec_kstart", 64'(ksa_start[0]), 64'd0);
        wait_until(0, S_NDEC, 50, "t1_chk", cyc);
        wait_until(0, S_FOUND, 100, "t1_found", cyc);
        chk("t1_check_len", 64'(cyc), 64'd32);
        chk("t1_key", 64'(secret_key[0]), 64'd0);
        chk("t1_busy", 64'(busy[0]), 64'd0);
        chk("t1_sfail", 64'(search_failed[0]), 64'd0);

        // Keys 0..2 rejected at byte 3, key 3 accepted.
        mode = 1;
        pulse_go(0);
        chk("t2_found_clr", 64'(key_found[0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            wait_until(0, S_DEC, 100, "t2_dec", cyc);
            chk("t2_dec_key", 64'(secret_key[0]), 64'(k));
            wait_until(0, S_NDEC, 50, "t2_chk", cyc);
            wait_until(0, S_SRST, 50, "t2_srst", cyc);
            chk("t2_reject_len", 64'(cyc), 64'd5);
            chk("t2_next_key", 64'(secret_key[0]), 64'(k + 1));
            @(negedge clk);
            chk("t2_srst_1cyc", 64'(sub_reset[0]), 64'd0);
            chk("t2_istart", 64'(init_start[0]), 64'd1);
        end
        wait_until(0, S_FOUND, 200, "t2_found", cyc);
        chk("t2_key", 64'(secret_key[0]), 64'd3);
        chk("t2_busy", 64'(busy[0]), 64'd0);

        // Range 10..12 all invalid.
        pulse_go(1);
        chk("t3_first_key", 64'(secret_key[1]), 64'd10);
        wait_until(1, S_SFAIL, 1000, "t3_sfail", cyc);
        chk("t3_key", 64'(secret_key[1]), 64'd12);
        chk("t3_found", 64'(key_found[1]), 64'd0);
        chk("t3_busy", 64'(busy[1]), 64'd0);
        chk("t3_tmo", 64'(timeout_err[1]), 64'd0);
        chk("t3_keys_tried", 64'(rs_count1), 64'd3);

        // Key schedule never finishes.
        ksa_hang = 1'b1;
        pulse_go(0);
        wait_until(0, S_KSA, 50, "t4_ksa", cyc);
        wait_until(0, S_TMO, 100, "t4_tmo", cyc);
        chk("t4_tmo_len", 64'(cyc), 64'd16);
        chk("t4_busy", 64'(busy[0]), 64'd0);
        chk("t4_sfail", 64'(search_failed[0]), 64'd0);
        chk("t4_found", 64'(key_found[0]), 64'd0);
        chk("t4_kstart", 64'(ksa_start[0]), 64'd0);
        ksa_hang = 1'b0;

        // Abort in WAIT_DEC at key 7.
        mode = 2;
        pulse_go(0);
        chk("t5_tmo_clr", 64'(timeout_err[0]), 64'd0);
        for (int n = 0; n < 12; n++) begin
            wait_until(0, S_DEC, 100, "t5_dec", cyc);
            if (secret_key[0] == 24'd7) break;
            wait_until(0, S_NDEC, 50, "t5_chk", cyc);
        end
        chk("t5_key_at_abort", 64'(secret_key[0]), 64'd7);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("t5_srst", 64'(sub_reset[0]), 64'd1);
        chk("t5_dstart", 64'(dec_start[0]), 64'd0);
        chk("t5_busy", 64'(busy[0]), 64'd0);
        chk("t5_key_held", 64'(secret_key[0]), 64'd7);
        abort[0] = 1'b1;
        repeat (2) @(negedge clk);
        abort[0] = 1'b0;
        chk("t5_idle_abort_key", 64'(secret_key[0]), 64'd7);
        chk("t5_idle_abort_busy", 64'(busy[0]), 64'd0);
        pulse_go(0);
        chk("t5_restart_key", 64'(secret_key[0]), 64'd0);
        chk("t5_restart_busy", 64'(busy[0]), 64'd1);

        // Reset mid-CHECK at key 2.
        for (int n = 0; n < 5; n++) begin
            wait_until(0, S_DEC, 100, "t6_dec", cyc);
            if (secret_key[0] == 24'd2) break;
            wait_until(0, S_NDEC, 50, "t6_chk", cyc);
        end
        chk("t6_key", 64'(secret_key[0]), 64'd2);
        mode = 0;
        wait_until(0, S_NDEC, 50, "t6_chk2", cyc);
        repeat (2) @(negedge clk);
        chk("t6_mid_busy", 64'(busy[0]), 64'd1);
        chk("t6_mid_srst", 64'(sub_reset[0]), 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset(0, 24'd0, "t6_rst");
        chk("t6_rst_sfail1", 64'(search_failed[1]), 64'd0);
        reset_n = 1'b1;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_spur_istart", 64'(init_start[0]), 64'd0);
        chk("t6_spur_kstart", 64'(ksa_start[0]), 64'd0);
        chk("t6_spur_busy", 64'(busy[0]), 64'd0);
        chk("t6_spur_srst", 64'(sub_reset[0]), 64'd1);
        spur = 1'b0;
        pulse_go(0);
        wait_until(0, S_FOUND, 300, "t6_found", cyc);
        chk("t6_final_key", 64'(secret_key[0]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
